// File: rtl/i2c_slave_regs.sv
// I2C slave with a 2^REG_AW byte register file, pointer auto-increment bursts,
// repeated START support, and a local read port plus write-notify strobe.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h53,
    parameter int         REG_AW     = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              SCL_i,
    input  logic              SDA_i,
    output logic              SDA_in_en,
    output logic              SDA_o,
    output logic              wr_stb,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    output logic              busy,
    output logic [2:0]        state_o
);

    localparam int DEPTH = 1 << REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        ACK_A   = 3'd2,
        WR_BYTE = 3'd3,
        ACK_W   = 3'd4,
        RD_BYTE = 3'd5,
        ACK_R   = 3'd6,
        IGNORE  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        scl_sync_q, sda_sync_q;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              first_q, first_d;
    logic              rw_q, rw_d;
    logic              drive_q, drive_d;
    logic              busy_q, busy_d;
    logic              wr_stb_q, wr_stb_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              reg_we;
    logic [7:0]        regs_q [DEPTH];

    logic scl_rise, scl_fall, scl_hi, sda_s, start_det, stop_det;

    // Bits [1] are the synchronised pins, bits [2] the history flops.
    // START/STOP only qualify while SCL is stable high, so a simultaneous
    // SCL change wins and suppresses them.
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign scl_hi    = scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_hi & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_hi & ~sda_sync_q[2] & sda_sync_q[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            rw_q       <= 1'b0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], SCL_i};
            sda_sync_q <= {sda_sync_q[1:0], SDA_i};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            rw_q       <= rw_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[ptr_q] <= shift_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        rw_d      = rw_q;
        drive_d   = drive_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;

        if (stop_det) begin
            state_d = IDLE;
            drive_d = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            drive_d = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d = ACK_A;
                            drive_d = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (!rw_q) begin
                            state_d = WR_BYTE;
                            first_d = 1'b1;
                            drive_d = 1'b0;
                        end else begin
                            // Bit 7 of the read byte goes out on the same fall that ends ACK.
                            state_d = RD_BYTE;
                            shift_d = regs_q[ptr_q];
                            drive_d = ~regs_q[ptr_q][7];
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d   = '0;
                        drive_d = 1'b1;
                        state_d = ACK_W;
                        if (first_q) begin
                            ptr_d   = shift_q[REG_AW-1:0];
                            first_d = 1'b0;
                        end else begin
                            reg_we    = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_q;
                            ptr_d     = ptr_q + PTR_ONE;
                        end
                    end
                end
                ACK_W: begin
                    if (scl_fall) begin
                        drive_d = 1'b0;
                        state_d = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d   = '0;
                            drive_d = 1'b0;
                            ptr_d   = ptr_q + PTR_ONE;
                            state_d = ACK_R;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            drive_d = ~shift_q[6];
                        end
                    end
                end
                ACK_R: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = IGNORE;
                        else       cnt_d   = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = '0;
                        shift_d = regs_q[ptr_q];
                        drive_d = ~regs_q[ptr_q][7];
                        state_d = RD_BYTE;
                    end
                end
                IGNORE: drive_d = 1'b0;
                default: begin
                    state_d = IDLE;
                    drive_d = 1'b0;
                end
            endcase
        end
    end

    // Open drain: the pad is either released (reads back 1) or pulled to 0.
    assign SDA_in_en = ~drive_q;
    assign SDA_o     = ~drive_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign loc_rdata = regs_q[loc_addr];
    assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bus master model drives SCL/SDA, a register-file
// model predicts bus reads, ACKs and write strobes.
module tb_i2c_slave_regs;

    localparam logic [6:0] DEV = 7'h53;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WR = 3'd3, ST_IGN = 3'd7;

    logic       clk = 1'b0;
    logic       rstn;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       SDA_in_en, SDA_o, wr_stb, busy;
    logic [3:0] wr_addr, loc_addr;
    logic [7:0] wr_data, loc_rdata;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_regs [16];
    int          m_ptr;
    logic [7:0]  buf_d [8];
    logic [11:0] exp_q [$];
    logic        watch_drv = 1'b0;
    int          drv_seen = 0;

    // Wired-AND bus: the slave can only pull low.
    assign sda_bus = sda_m & (SDA_in_en | SDA_o);

    i2c_slave_regs #(.SLAVE_ADDR(DEV), .REG_AW(4)) dut (
        .clk(clk), .rstn(rstn), .SCL_i(scl_m), .SDA_i(sda_bus),
        .SDA_in_en(SDA_in_en), .SDA_o(SDA_o), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data), .loc_addr(loc_addr),
        .loc_rdata(loc_rdata), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rstn === 1'b1 && wr_stb === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=0x%0h expected none", wr_addr, wr_data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                             wr_addr, wr_data, e[11:8], e[7:0]);
                end
            end
        end
        if (watch_drv && SDA_in_en !== 1'b1) drv_seen++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b, output logic sampled);
        sda_m = b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(9);
        sampled = sda_bus;
        wait_clk(1);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i], s);
        bit_out(1'b1, nack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, s);
            b[i] = s;
        end
        bit_out(nack, s);
    endtask

    // START, address+W, pointer byte, then n data bytes from buf_d.
    task automatic txn_write(input logic [6:0] addr, input logic [7:0] ptr, input int n, input bit do_stop);
        logic nk;
        bit   match;
        match = (addr == DEV);
        i2c_start();
        write_byte({addr, 1'b0}, nk);
        check("addr_ack", nk, !match);
        write_byte(ptr, nk);
        check("ptr_ack", nk, !match);
        if (match) m_ptr = ptr % 16;
        for (int i = 0; i < n; i++) begin
            if (match) begin
                exp_q.push_back({m_ptr[3:0], buf_d[i]});
                m_regs[m_ptr] = buf_d[i];
                m_ptr = (m_ptr + 1) % 16;
            end
            write_byte(buf_d[i], nk);
            check("data_ack", nk, !match);
        end
        if (do_stop) begin
            i2c_stop();
            check("busy_after_stop", busy, 1'b0);
        end
    endtask

    // (Repeated) START, address+R, n bytes read, NACK on the last.
    task automatic txn_read(input int n);
        logic       nk;
        logic [7:0] b;
        i2c_start();
        write_byte({DEV, 1'b1}, nk);
        check("rd_addr_ack", nk, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i == n - 1);
            check("rd_byte", b, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % 16;
        end
        check("rd_release", SDA_in_en, 1'b1);
        check("rd_ignore_state", state_o, ST_IGN);
    endtask

    task automatic check_regs();
        for (int a = 0; a < 16; a++) begin
            loc_addr = a[3:0];
            #1;
            check("loc_rdata", loc_rdata, m_regs[a]);
        end
    endtask

    initial begin
        logic nk;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        loc_addr = '0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rstn  = 1'b0;
        wait_clk(3);
        check("rst_in_en", SDA_in_en, 1'b1);
        check("rst_sda_o", SDA_o, 1'b1);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_o, ST_IDLE);
        rstn = 1'b1;
        wait_clk(5);

        // Directed write burst.
        buf_d[0] = 8'hA5;
        buf_d[1] = 8'h3C;
        txn_write(DEV, 8'h02, 2, 1'b0);
        check("busy_in_txn", busy, 1'b1);
        i2c_stop();
        check("busy_stop", busy, 1'b0);
        loc_addr = 4'd3;
        #1;
        check("loc3", loc_rdata, 8'h3C);

        // Repeated-START read of the same two bytes.
        txn_write(DEV, 8'h02, 0, 1'b0);
        txn_read(2);
        i2c_stop();

        // Address mismatch: slave must never pull SDA.
        drv_seen  = 0;
        watch_drv = 1'b1;
        i2c_start();
        write_byte(8'hA0, nk);
        check("mis_addr_nack", nk, 1'b1);
        write_byte(8'h11, nk);
        check("mis_data_nack", nk, 1'b1);
        check("mis_state", state_o, ST_IGN);
        check("mis_busy", busy, 1'b1);
        i2c_stop();
        watch_drv = 1'b0;
        check("mis_no_drive", drv_seen, 0);
        check("mis_idle", state_o, ST_IDLE);

        // Pointer wrap.
        buf_d[0] = 8'h11;
        buf_d[1] = 8'h22;
        txn_write(DEV, 8'h0F, 2, 1'b1);
        check_regs();

        // Glitch: SCL and SDA change in the same clk while SCL is high.
        i2c_start();
        write_byte({DEV, 1'b0}, nk);
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        scl_m = 1'b0;
        wait_clk(10);
        check("glitch_fall_state", state_o, ST_WR);
        check("glitch_fall_busy", busy, 1'b1);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(10);
        check("glitch_rise_state", state_o, ST_WR);
        check("glitch_rise_busy", busy, 1'b1);
        scl_m = 1'b0;
        wait_clk(5);
        i2c_stop();
        check("glitch_stop_busy", busy, 1'b0);

        // Randomised bursts with occasional repeated-START read-back.
        repeat (12) begin
            logic [6:0] a;
            logic [7:0] p;
            int         n;
            a = ($urandom_range(0, 9) < 8) ? DEV : 7'($urandom_range(0, 127));
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom_range(0, 255));
            if (a == DEV && $urandom_range(0, 1) == 1) begin
                txn_write(a, p, n, 1'b0);
                txn_write(DEV, 8'($urandom_range(0, 255)), 0, 1'b0);
                txn_read($urandom_range(1, 3));
                i2c_stop();
            end else begin
                txn_write(a, p, n, 1'b1);
            end
            check_regs();
        end

        // Reset while the slave is driving a 0 data bit.
        buf_d[0] = 8'h00;
        txn_write(DEV, 8'h05, 1, 1'b0);
        txn_write(DEV, 8'h05, 0, 1'b0);
        i2c_start();
        write_byte({DEV, 1'b1}, nk);
        check("rr_addr_ack", nk, 1'b0);
        check("rr_driving0", SDA_in_en, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("rr_in_en", SDA_in_en, 1'b1);
        check("rr_sda_o", SDA_o, 1'b1);
        check("rr_busy", busy, 1'b0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(5);
        check("rr_state", state_o, ST_IDLE);
        check_regs();

        check("wr_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
